// File: rtl/vend_dispenser.sv
// Vend dispenser: FIFO of vend requests feeding a motor/drop/change FSM.
// Optional VEND_STATS_EN adds saturating vend and change counters.
module vend_dispenser #(
  parameter int MOTOR_CYCLES = 8,
  parameter int TIMEOUT      = 64,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_in,
  input  logic       c_in,
  input  logic       drop_sense,
  input  logic       coin_sense,
  input  logic       fault_clr,
  output logic       motor_en,
  output logic       hopper_en,
  output logic       busy,
  output logic       full,
  output logic       overflow,
`ifdef VEND_STATS_EN
  output logic [7:0] vend_cnt,
  output logic [7:0] change_cnt,
`endif
  output logic       fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [7:0]  L_MOT   = 8'(MOTOR_CYCLES);
  localparam logic [9:0]  L_TMO   = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_WAIT_DROP,
    S_CHANGE,
    S_FAULT
  } state_t;

  state_t           r_state;
  logic [DEPTH-1:0] r_q;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic [7:0]       r_mcnt;
  logic [9:0]       r_tmr;
  logic             r_chg;
  logic             r_motor;
  logic             r_hopper;
  logic             r_fault;
  logic             r_ovf;

  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop in the same cycle frees a slot for the incoming push
  assign w_pop  = (r_state == S_IDLE) && (r_cnt != '0);
  assign w_push = p_in && ((r_cnt != L_DEPTH) || w_pop);
  assign w_drop = p_in && !w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= c_in;
        r_wp      <= r_wp + AW'(1);
      end
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
      else if (fault_clr)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_chg    <= 1'b0;
      r_mcnt   <= '0;
      r_tmr    <= '0;
      r_motor  <= 1'b0;
      r_hopper <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_chg   <= r_q[r_rp];
            r_mcnt  <= L_MOT;
            r_state <= S_VEND;
          end
        end
        S_VEND: begin
          if (r_mcnt != '0) begin
            r_motor <= 1'b1;
            r_mcnt  <= r_mcnt - 8'd1;
          end else begin
            r_motor <= 1'b0;
            r_tmr   <= L_TMO;
            r_state <= S_WAIT_DROP;
          end
        end
        S_WAIT_DROP: begin
          if (drop_sense) begin
            if (r_chg) begin
              r_hopper <= 1'b1;
              r_tmr    <= L_TMO;
              r_state  <= S_CHANGE;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_tmr == 10'd1) begin
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else begin
            r_tmr <= r_tmr - 10'd1;
          end
        end
        S_CHANGE: begin
          if (coin_sense) begin
            r_hopper <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_tmr == 10'd1) begin
            r_hopper <= 1'b0;
            r_fault  <= 1'b1;
            r_state  <= S_FAULT;
          end else begin
            r_tmr <= r_tmr - 10'd1;
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            r_fault <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VEND_STATS_EN
  logic [7:0] r_vcnt;
  logic [7:0] r_ccnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vcnt <= '0;
      r_ccnt <= '0;
    end else begin
      if (r_state == S_WAIT_DROP && drop_sense && r_vcnt != 8'hFF)
        r_vcnt <= r_vcnt + 8'd1;
      if (r_state == S_CHANGE && coin_sense && r_ccnt != 8'hFF)
        r_ccnt <= r_ccnt + 8'd1;
    end
  end

  assign vend_cnt   = r_vcnt;
  assign change_cnt = r_ccnt;
`endif

  assign motor_en  = r_motor;
  assign hopper_en = r_hopper;
  assign fault     = r_fault;
  assign overflow  = r_ovf;
  assign full      = (r_cnt == L_DEPTH);
  assign busy      = (r_state != S_IDLE) || (r_cnt != '0);

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 SHALL have parameter MOTOR_CYCLES, default 8, cycles motor_en is held per vend (1..255).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles to wait for a sensor before fault (1..1023).
REQ-003 SHALL have parameter DEPTH, default 4, request queue entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port p_in  input  1  one-cycle vend request pulse from the coin FSM.
REQ-007 SHALL have port c_in  input  1  change-owed flag, qualified by p_in in the same cycle.
REQ-008 SHALL have port drop_sense  input  1  product-drop sensor, synchronous, active-high.
REQ-009 SHALL have port coin_sense  input  1  change-coin ejected sensor, synchronous, active-high.
REQ-010 SHALL have port fault_clr  input  1  single-cycle fault and overflow clear.
REQ-011 SHALL have port motor_en  output  1  product motor drive, registered.
REQ-012 SHALL have port hopper_en  output  1  change hopper drive, registered.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE or queue non-empty.
REQ-014 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-015 SHALL have port overflow  output  1  sticky: a request was dropped.
REQ-016 SHALL have port fault  output  1  high while in FAULT state.

Function
REQ-017 SHALL push entry {chg=c_in} on every rising edge where p_in=1 and the queue is not full after any same-cycle pop; c_in with p_in=0 SHALL be ignored.
REQ-018 SHALL drop a push when full and no same-cycle pop, and set overflow on that edge.
REQ-019 SHALL implement states IDLE, VEND, WAIT_DROP, CHANGE, FAULT.
REQ-020 IDLE: if queue non-empty, pop head, latch chg, go VEND, load counter with MOTOR_CYCLES; else stay.
REQ-021 VEND: motor_en=1 for exactly MOTOR_CYCLES consecutive cycles, then WAIT_DROP with timer loaded to TIMEOUT; drop_sense ignored in VEND.
REQ-022 WAIT_DROP: drop_sense=1 -> CHANGE if chg else IDLE; timer expiry without drop_sense -> FAULT.
REQ-023 CHANGE: hopper_en=1 until coin_sense=1 (-> IDLE, hopper_en=0 next cycle) or TIMEOUT cycles elapse (-> FAULT).
REQ-024 FAULT: motor_en=0, hopper_en=0, fault=1; queue keeps accepting pushes; fault_clr=1 -> IDLE; popped entry in progress is discarded.
REQ-025 fault_clr SHALL also clear overflow in any state; fault_clr outside FAULT SHALL not change state.
REQ-026 Latency: p_in sampled at edge n with empty queue and IDLE -> motor_en high from edge n+2.
REQ-027 motor_en and hopper_en SHALL never be high in the same cycle.
REQ-028 Queue pointers SHALL wrap modulo DEPTH; entries SHALL be served strictly FIFO.

Reset
REQ-029 rst SHALL immediately force state IDLE, queue empty, motor_en=0, hopper_en=0, busy=0, full=0, overflow=0, fault=0, counters 0, independent of clk.
REQ-030 rst asserted mid-VEND or mid-CHANGE SHALL discard the in-progress request and all queued entries.

Configuration
REQ-031 With macro VEND_STATS_EN defined, SHALL add outputs vend_cnt[7:0] and change_cnt[7:0], incremented on each drop_sense completion in WAIT_DROP and each coin_sense completion in CHANGE, saturating at 255, reset to 0.
REQ-032 Without VEND_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification (MOTOR_CYCLES=8, TIMEOUT=64, DEPTH=4)
REQ-033 p_in=1,c_in=0 one cycle; drop_sense at 3rd WAIT_DROP cycle -> motor_en high 8 cycles, hopper_en never high, busy low after return to IDLE.
REQ-034 p_in=1,c_in=1; drop_sense then coin_sense 5 cycles later -> hopper_en high exactly 5 cycles after drop, then IDLE; vend_cnt=1, change_cnt=1 when VEND_STATS_EN.
REQ-035 Six p_in pulses back-to-back while first vend is in VEND -> full=1 after 4 queued, overflow=1, exactly 5 vends served in order.
REQ-036 No drop_sense after vend -> fault=1 exactly 64 cycles after entering WAIT_DROP; fault_clr -> IDLE and next queued request served.
REQ-037 rst asserted during 4th motor_en cycle -> motor_en=0 without clock edge, queue empty, no further vends.
